// File: rtl/booth_seq_mult.sv
// Iterative radix-4 Booth multiplier, one partial product per clock.
// Valid/ready on both sides; signed or unsigned per transaction.
module booth_seq_mult #(
   parameter int WORDLEN = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_signed,
   input  logic [WORDLEN-1:0]     A,
   input  logic [WORDLEN-1:0]     B,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2*WORDLEN-1:0]   Result,
   output logic                   busy
);

   localparam int N_ITER = WORDLEN / 2 + 1;
   localparam int EW     = WORDLEN + 2;
   localparam int AW     = 2 * WORDLEN + 2;
   localparam int CW     = $clog2(N_ITER);

   if (WORDLEN < 4 || (WORDLEN % 2) != 0) begin : g_bad_wordlen
      $error("booth_seq_mult: WORDLEN must be even and >= 4");
   end

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [AW-1:0]       acc;
   logic [AW-1:0]       acc_nxt;
   logic [AW-1:0]       mcand;
   logic [EW:0]         bsh;
   logic [CW-1:0]       cnt;
   logic [2*WORDLEN-1:0] result_q;
   logic                accept;
   logic                last;
   logic [2:0]          trip;
   logic [AW-1:0]       sel;
   logic                inv;
   logic                d_zero, d_p1, d_p2, d_m1, d_m2;
   logic                a_sx, b_sx;

   assign accept = in_valid && (state == IDLE);
   assign last   = (cnt == CW'(N_ITER - 1));
   assign trip   = bsh[2:0];
   assign a_sx   = in_signed & A[WORDLEN-1];
   assign b_sx   = in_signed & B[WORDLEN-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = BUSY;
         end
         BUSY: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Booth digit from {b[2i+1], b[2i], b[2i-1]}
   always_comb begin
      d_zero = (trip == 3'b000) || (trip == 3'b111);
      d_p1   = (trip == 3'b001) || (trip == 3'b010);
      d_p2   = (trip == 3'b011);
      d_m2   = (trip == 3'b100);
      d_m1   = (trip == 3'b101) || (trip == 3'b110);
      sel    = '0;
      inv    = 1'b0;
      unique case (1'b1)
         d_zero: sel = '0;
         d_p1:   sel = mcand;
         d_p2:   sel = mcand << 1;
         d_m1: begin
            sel = mcand;
            inv = 1'b1;
         end
         d_m2: begin
            sel = mcand << 1;
            inv = 1'b1;
         end
         default: sel = '0;
      endcase
   end

   // negation: invert here, the +1 enters as carry-in
   assign acc_nxt = acc + (sel ^ {AW{inv}}) + AW'(inv);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         mcand    <= '0;
         bsh      <= '0;
         cnt      <= '0;
         result_q <= '0;
      end else if (accept) begin
         acc   <= '0;
         cnt   <= '0;
         mcand <= {{(WORDLEN + 2){a_sx}}, A};
         bsh   <= {{2{b_sx}}, B, 1'b0};
      end else if (state == BUSY) begin
         acc   <= acc_nxt;
         mcand <= mcand << 2;
         bsh   <= bsh >> 2;
         cnt   <= cnt + 1'b1;
         if (last) result_q <= acc_nxt[2*WORDLEN-1:0];
      end
   end

   assign Result = result_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Scoreboard bench for booth_seq_mult at WORDLEN=8.
// Directed vectors; monitor pops expected products on each handshake.
module tb_booth_seq_mult;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic           in_signed;
   logic [W-1:0]   A;
   logic [W-1:0]   B;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] Result;
   logic           busy;

   int n_chk = 0;
   int n_err = 0;
   logic [2*W-1:0] exp_q[$];

   booth_seq_mult #(.WORDLEN(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_signed (in_signed),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Result    (Result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard monitor
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_output: got %0h expected none",
                        Result);
            end else begin
               chk("result", 32'(Result), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   // issue one product; hold > 0 applies backpressure for that many cycles
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [2*W-1:0] exp,
                        input int hold);
      int lat;
      int bcnt;
      @(negedge clk);
      out_ready = (hold == 0);
      in_valid  = 1'b1;
      A         = a;
      B         = b;
      in_signed = s;
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      @(posedge clk);
      exp_q.push_back(exp);
      @(negedge clk);
      in_valid = 1'b0;
      lat  = 1;
      bcnt = 0;
      while (!out_valid && lat < 20) begin
         if (busy) bcnt++;
         A = W'($urandom);
         B = W'($urandom);
         in_signed = ~s;
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'd6);
      chk("busy_cycles", 32'(bcnt), 32'd5);
      chk("busy_done", 32'(busy), 32'd0);
      for (int k = 0; k < hold; k++) begin
         in_valid = 1'b1;
         A = 8'h77;
         B = 8'h66;
         #2;
         chk("hold_result", 32'(Result), 32'(exp));
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      if (hold > 0) begin
         in_valid  = 1'b0;
         out_ready = 1'b1;
         @(negedge clk);
         chk("bp_idle_ready", 32'(in_ready), 32'd1);
         chk("bp_valid_low", 32'(out_valid), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_signed = 1'b0;
      A         = '0;
      B         = '0;
      out_ready = 1'b1;
      #12;
      chk("rst_result", 32'(Result), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      do_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
      do_op(8'h80, 8'h80, 1'b1, 16'h4000, 0);
      do_op(8'hFF, 8'h7F, 1'b1, 16'hFF81, 0);
      do_op(8'hFF, 8'h7F, 1'b0, 16'h7E81, 0);
      do_op(8'h12, 8'h34, 1'b0, 16'h03A8, 4);
      do_op(8'h80, 8'h7F, 1'b1, 16'hC080, 0);
      do_op(8'h7F, 8'h7F, 1'b1, 16'h3F01, 0);
      do_op(8'h00, 8'hAB, 1'b1, 16'h0000, 0);
      do_op(8'hFF, 8'hFF, 1'b1, 16'h0001, 0);
      do_op(8'h80, 8'hFF, 1'b0, 16'h7F80, 0);
      do_op(8'h80, 8'h01, 1'b1, 16'hFF80, 0);
      do_op(8'h55, 8'hAA, 1'b0, 16'h3872, 0);

      // reset during BUSY: in-flight product must vanish
      @(negedge clk);
      in_valid  = 1'b1;
      in_signed = 1'b0;
      A         = 8'hAA;
      B         = 8'h55;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_result", 32'(Result), 32'd0);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(8'h03, 8'h04, 1'b0, 16'h000C, 0);

      repeat (12) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/booth_seq_mult.md
Name: booth_seq_mult

Overview:
- Iterative radix-4 Booth multiplier. Parametrised in operand width; selectable signed/unsigned mode per transaction.
- Retires one Booth partial product per clock into an accumulator, replacing the fully combinational Booth + Wallace tree with a small multi-cycle datapath.
- Sits between an operand producer and a result consumer with valid/ready handshakes on both sides.

Parameters:
- WORDLEN, 8, operand width in bits. Must be even and >= 4; other values are illegal, and the implementation traps them with an elaboration-time error.
- N_ITER, WORDLEN/2+1 (derived localparam, not overridable), number of Booth digits processed per product.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned
- A  input  WORDLEN  multiplicand
- B  input  WORDLEN  multiplier (Booth-recoded operand)
- out_valid  output  1  Result valid
- out_ready  input  1  consumer takes Result
- Result  output  2*WORDLEN  product
- busy  output  1  high while in BUSY state

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, accumulator=0, Result=0, out_valid=0, busy=0, in_ready=1 once reset is released. Reset mid-operation discards the in-flight product; no output is produced for it.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a rising edge: latch A, B and in_signed; clear the accumulator and iteration counter; go to BUSY.
- BUSY:
  - in_ready=0, busy=1.
  - Each cycle, recode one Booth digit from the extended multiplier triple {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
  - Digit set {-2,-1,0,+1,+2}. Selected multiple of the extended multiplicand is shifted left by 2i and added to the 2*WORDLEN+2 bit accumulator.
  - Counter runs i = 0..N_ITER-1. After the last digit, go to DONE.
- Extension rules:
  - B is extended to WORDLEN+2 bits: sign-extended when in_signed=1, zero-extended when in_signed=0. This extra digit makes unsigned products correct; in signed mode it recodes to 0.
  - A is extended to WORDLEN+2 bits with the same rule before forming +-1x/+-2x.
  - Negation is two's complement (invert plus 1 folded into the add). No separate carry vector is kept.
- DONE:
  - out_valid=1. Result = accumulator[2*WORDLEN-1:0], held stable while out_ready=0.
  - On out_valid&&out_ready: out_valid falls and state returns to IDLE. The next operand is accepted no earlier than the following cycle, so there is no same-cycle accept/complete overlap.
- Latency:
  - Accept edge = cycle 0. BUSY occupies cycles 1..N_ITER. out_valid is high from cycle N_ITER+1.
  - For WORDLEN=8 this is 5 BUSY cycles and out_valid at cycle 6.
  - Throughput: at most one product per N_ITER+2 cycles.
- Result semantics: exact product modulo 2^(2*WORDLEN). Signed: two's-complement product; the full range fits, including (-2^(W-1))^2. Unsigned: unsigned product.
- in_valid while in_ready=0 is ignored. Operands need not be held after acceptance.
- A and B input changes during BUSY/DONE must not affect Result.
- Result is registered; no combinational path from inputs to Result or out_valid.
- in_ready depends only on state; it is not derived from out_ready.

Test Plan:
- WORDLEN=8, unsigned, A=0xFF, B=0xFF -> out_valid at cycle 6 after accept, Result=0xFE01; busy high exactly cycles 1..5.
- WORDLEN=8, signed, A=0x80, B=0x80 -> Result=0x4000. Then signed A=0xFF (-1), B=0x7F -> Result=0xFF81. Same bits unsigned (0xFF x 0x7F) -> Result=0x7E81.
- Backpressure: complete a product 0x12 x 0x34 unsigned, hold out_ready=0 for 4 cycles -> Result=0x03A8 stable, out_valid=1, in_ready=0 throughout, new in_valid ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-operation: accept 0xAA x 0x55, drop rst_n at cycle 3 (asynchronous, between edges) -> outputs immediately Result=0, out_valid=0, busy=0. After release, a new 0x03 x 0x04 -> Result=0x000C with no stale output.
- Operand-hold check: change A/B every cycle during BUSY -> Result equals the product of the accepted values.
- Randomised and exhaustive sweep at WORDLEN=8 (all 65536 pairs, both modes), plus random at WORDLEN=16 and WORDLEN=4, against the behavioural A*B product -> zero mismatches; out_valid latency always N_ITER+1.
